// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between the EX stage (port 0)
// and the debug unit (port 1); operands are registered, the result is held until accepted.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req0_valid,
  output logic                  o_req0_ready,
  input  logic [CTRL_WIDTH-1:0] i_req0_ctrl,
  input  logic [DATA_WIDTH-1:0] i_req0_a,
  input  logic [DATA_WIDTH-1:0] i_req0_b,
  input  logic                  i_req1_valid,
  output logic                  o_req1_ready,
  input  logic [CTRL_WIDTH-1:0] i_req1_ctrl,
  input  logic [DATA_WIDTH-1:0] i_req1_a,
  input  logic [DATA_WIDTH-1:0] i_req1_b,
  output logic [CTRL_WIDTH-1:0] o_alu_ctrl,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_id,
  output logic [DATA_WIDTH-1:0] o_rsp_result,
  output logic                  o_rsp_illegal,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a request (or response) transfers on a rising edge where valid and
  // ready are both high; ready never depends on ctrl/operand values.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_rr_ptr;
  logic                  r_grant_id;
  logic                  r_op_illegal;
  logic [CTRL_WIDTH-1:0] r_alu_ctrl;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic                  r_rsp_id;
  logic                  r_rsp_illegal;
  logic [DATA_WIDTH-1:0] r_rsp_result;

  logic                  w_window;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [CTRL_WIDTH-1:0] w_sel_ctrl;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic                  w_sel_legal;

  function automatic logic is_legal(input logic [CTRL_WIDTH-1:0] c);
    logic ok;
    ok = (c == CTRL_WIDTH'(6'b000000)) || (c == CTRL_WIDTH'(6'b000010)) ||
         (c == CTRL_WIDTH'(6'b000011)) || (c == CTRL_WIDTH'(6'b000100)) ||
         (c == CTRL_WIDTH'(6'b000110)) || (c == CTRL_WIDTH'(6'b000111)) ||
         (c == CTRL_WIDTH'(6'b001001)) || (c == CTRL_WIDTH'(6'b101010)) ||
         ((c >= CTRL_WIDTH'(6'b100000)) && (c <= CTRL_WIDTH'(6'b100111)));
    return ok;
  endfunction

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next_state = S_EXEC;
      S_EXEC: w_next_state = S_RESP;
      S_RESP: if (i_rsp_ready) w_next_state = w_accept ? S_EXEC : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output logic; the accept window reopens in RESP as soon as the response retires
  always_comb begin
    w_window     = !i_reset && ((r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready));
    o_req0_ready = w_window && (!i_req1_valid || !r_rr_ptr);
    o_req1_ready = w_window && (!i_req0_valid || r_rr_ptr);
    o_rsp_valid  = (r_state == S_RESP);
    o_busy       = (r_state != S_IDLE);
    o_dbg_state  = r_state;
  end

  assign w_grant0    = i_req0_valid && o_req0_ready;
  assign w_grant1    = i_req1_valid && o_req1_ready;
  assign w_accept    = w_grant0 || w_grant1;
  assign w_sel_ctrl  = w_grant1 ? i_req1_ctrl : i_req0_ctrl;
  assign w_sel_a     = w_grant1 ? i_req1_a : i_req0_a;
  assign w_sel_b     = w_grant1 ? i_req1_b : i_req0_b;
  assign w_sel_legal = is_legal(w_sel_ctrl);

  // Operand and grant capture on accept; pointer moves to the port not just served
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr_ptr     <= 1'b0;
      r_grant_id   <= 1'b0;
      r_op_illegal <= 1'b0;
      r_alu_ctrl   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
    end else if (w_accept) begin
      r_rr_ptr     <= !w_grant1;
      r_grant_id   <= w_grant1;
      r_op_illegal <= !w_sel_legal;
      r_alu_ctrl   <= w_sel_ctrl;
      r_alu_a      <= w_sel_a;
      r_alu_b      <= w_sel_b;
    end
  end

  // Result capture in EXEC; illegal codes never forward whatever the alu drives
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rsp_id      <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_result  <= '0;
    end else if (r_state == S_EXEC) begin
      r_rsp_id      <= r_grant_id;
      r_rsp_illegal <= r_op_illegal;
      r_rsp_result  <= r_op_illegal ? '0 : i_alu_result;
    end
  end

  assign o_alu_ctrl    = r_alu_ctrl;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_rsp_id      = r_rsp_id;
  assign o_rsp_illegal = r_rsp_illegal;
  assign o_rsp_result  = r_rsp_result;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: an alu model closes the loop and a response
// scoreboard checks id/illegal/result of every retired response in order.
module tb_alu_arbiter;

  localparam int DW  = 32;
  localparam int CW  = 6;
  localparam int SBW = DW + 2;

  localparam logic [CW-1:0] OP_SLL = 6'b000000;
  localparam logic [CW-1:0] OP_SRA = 6'b000011;
  localparam logic [CW-1:0] OP_ADD = 6'b100000;
  localparam logic [CW-1:0] OP_SUB = 6'b100010;
  localparam logic [CW-1:0] OP_OR  = 6'b100101;
  localparam logic [CW-1:0] OP_BAD = 6'b111111;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CW-1:0] req0_ctrl, req1_ctrl, alu_ctrl;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_illegal, busy;
  logic [DW-1:0] rsp_result;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [SBW-1:0] exp_q[$];
  logic [SBW-1:0] mon_exp;

  // Clock / reset
  always #5 clk = ~clk;

  alu_arbiter #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_ctrl(req0_ctrl),
    .i_req0_a(req0_a), .i_req0_b(req0_b),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_ctrl(req1_ctrl),
    .i_req1_a(req1_a), .i_req1_b(req1_b),
    .o_alu_ctrl(alu_ctrl), .o_alu_a(alu_a), .o_alu_b(alu_b), .i_alu_result(alu_result),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
    .o_rsp_result(rsp_result), .o_rsp_illegal(rsp_illegal), .o_busy(busy),
    .o_dbg_state(dbg_state)
  );

  // Alu model; unknown codes drive a poison value that must never reach the response
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    case (alu_ctrl)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_SLL:  alu_result = alu_b << alu_a[4:0];
      OP_SRA:  alu_result = DW'($signed(alu_b) >>> alu_a[4:0]);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
  endtask

  task automatic drive1(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
  endtask

  task automatic expect_rsp(input logic id, input logic ill, input logic [DW-1:0] res);
    exp_q.push_back({id, ill, res});
  endtask

  // Scoreboard: every response handshake is compared against the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("sb_id", 64'(rsp_id), 64'(mon_exp[DW+1]));
        chk("sb_illegal", 64'(rsp_illegal), 64'(mon_exp[DW]));
        chk("sb_result", 64'(rsp_result), 64'(mon_exp[DW-1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive0(1'b1, OP_ADD, 32'd1, 32'd1);
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc(); cyc();
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);

    // Single ADD on port 0
    rst = 1'b0;
    drive0(1'b1, OP_ADD, 32'd5, 32'd7);
    #1;
    chk("add_ready0", 64'(req0_ready), 64'd1);
    chk("add_ready1", 64'(req1_ready), 64'd0);
    expect_rsp(1'b0, 1'b0, 32'd12);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    chk("add_exec_busy", 64'(busy), 64'd1);
    chk("add_exec_valid", 64'(rsp_valid), 64'd0);
    chk("add_alu_a", 64'(alu_a), 64'd5);
    chk("add_alu_ctrl", 64'(alu_ctrl), 64'(OP_ADD));
    cyc();
    chk("add_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("add_rsp_id", 64'(rsp_id), 64'd0);
    chk("add_rsp_result", 64'(rsp_result), 64'd12);
    rsp_ready = 1'b1;
    cyc();
    chk("add_retired", 64'(rsp_valid), 64'd0);
    chk("add_idle", 64'(busy), 64'd0);

    // Contention after reset: port 0 first, then port 1, pointer alternating
    rst = 1'b1; cyc(); rst = 1'b0;
    drive0(1'b1, OP_SUB, 32'd9, 32'd3);
    drive1(1'b1, OP_OR, 32'hF0, 32'h0F);
    #1;
    chk("cont_ready0", 64'(req0_ready), 64'd1);
    chk("cont_ready1", 64'(req1_ready), 64'd0);
    expect_rsp(1'b0, 1'b0, 32'd6);
    expect_rsp(1'b1, 1'b0, 32'hFF);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    chk("exec_ready0", 64'(req0_ready), 64'd0);
    chk("exec_ready1", 64'(req1_ready), 64'd0);
    cyc();
    chk("resp_ready1", 64'(req1_ready), 64'd1);
    cyc();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    chk("b2b_exec_valid", 64'(rsp_valid), 64'd0);
    cyc(); cyc();
    drive0(1'b1, OP_ADD, 32'd1, 32'd1);
    drive1(1'b1, OP_ADD, 32'd2, 32'd2);
    #1;
    chk("rr_grant0", 64'(req0_ready), 64'd1);
    expect_rsp(1'b0, 1'b0, 32'd2);
    cyc();
    drive0(1'b1, OP_ADD, 32'd3, 32'd3);
    cyc();
    chk("rr_grant1_r1", 64'(req1_ready), 64'd1);
    chk("rr_grant1_r0", 64'(req0_ready), 64'd0);
    expect_rsp(1'b1, 1'b0, 32'd4);
    cyc();
    drive1(1'b1, OP_ADD, 32'd4, 32'd4);
    cyc();
    chk("rr_grant0b_r0", 64'(req0_ready), 64'd1);
    chk("rr_grant0b_r1", 64'(req1_ready), 64'd0);
    expect_rsp(1'b0, 1'b0, 32'd6);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc();
    chk("rr_grant1b_r1", 64'(req1_ready), 64'd1);
    expect_rsp(1'b1, 1'b0, 32'd8);
    cyc();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc(); cyc();

    // Illegal code on port 1, then a legal op
    drive1(1'b1, OP_BAD, 32'd3, 32'd4);
    #1;
    chk("ill_ready1", 64'(req1_ready), 64'd1);
    expect_rsp(1'b1, 1'b1, 32'd0);
    cyc();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc();
    chk("ill_flag", 64'(rsp_illegal), 64'd1);
    chk("ill_result", 64'(rsp_result), 64'd0);
    chk("ill_id", 64'(rsp_id), 64'd1);
    drive0(1'b1, OP_ADD, 32'd1, 32'd2);
    expect_rsp(1'b0, 1'b0, 32'd3);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc();
    chk("legal_after_ill", 64'(rsp_illegal), 64'd0);
    cyc();

    // Backpressure in RESP for 5 cycles with a pending port 0 request
    rsp_ready = 1'b0;
    drive0(1'b1, OP_ADD, 32'd10, 32'd20);
    expect_rsp(1'b0, 1'b0, 32'd30);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc();
    drive0(1'b1, OP_ADD, 32'd100, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_result", 64'(rsp_result), 64'd30);
      chk("bp_ready0", 64'(req0_ready), 64'd0);
      chk("bp_ready1", 64'(req1_ready), 64'd0);
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready0", 64'(req0_ready), 64'd1);
    expect_rsp(1'b0, 1'b0, 32'd101);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    chk("bp_b2b_valid", 64'(rsp_valid), 64'd0);
    chk("bp_b2b_busy", 64'(busy), 64'd1);
    cyc(); cyc();

    // Reset during EXEC drops the operation
    drive1(1'b1, OP_ADD, 32'd7, 32'd7);
    #1;
    chk("rx_ready1", 64'(req1_ready), 64'd1);
    cyc();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("rx_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rx_busy", 64'(busy), 64'd0);
    chk("rx_alu_a", 64'(alu_a), 64'd0);
    chk("rx_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rx_rsp_result", 64'(rsp_result), 64'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc();
    chk("rx_no_rsp", 64'(rsp_valid), 64'd0);
    drive0(1'b1, OP_ADD, 32'd1, 32'd1);
    drive1(1'b1, OP_ADD, 32'd2, 32'd2);
    #1;
    chk("rx_first_grant0", 64'(req0_ready), 64'd1);
    chk("rx_first_grant1", 64'(req1_ready), 64'd0);
    expect_rsp(1'b0, 1'b0, 32'd2);
    expect_rsp(1'b1, 1'b0, 32'd4);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc(); cyc();
    drive1(1'b0, OP_ADD, 32'd0, 32'd0);
    cyc(); cyc();

    // Back-to-back shifts
    drive0(1'b1, OP_SLL, 32'd4, 32'd1);
    expect_rsp(1'b0, 1'b0, 32'h10);
    expect_rsp(1'b0, 1'b0, 32'hC000_0000);
    cyc();
    drive0(1'b1, OP_SRA, 32'd1, 32'h8000_0000);
    cyc();
    chk("sll_result", 64'(rsp_result), 64'h10);
    chk("sll_ready0", 64'(req0_ready), 64'd1);
    cyc();
    drive0(1'b0, OP_ADD, 32'd0, 32'd0);
    chk("sra_exec_valid", 64'(rsp_valid), 64'd0);
    cyc();
    chk("sra_valid", 64'(rsp_valid), 64'd1);
    chk("sra_result", 64'(rsp_result), 64'hC000_0000);
    cyc(); cyc();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
